fpu_add_sched: RTL
==================

# fpu_add_sched

Sequencer and arbiter that shares one single-precision floating-point adder core (compare → align/add → round → normalize path) between two requesters. It accepts add/subtract operations over valid/ready handshakes and grants round-robin. It drives the core's operand inputs from registers, waits a fixed core latency, and captures the result. It returns the result to the owning requester over a valid/ready response channel, with one operation in flight at a time.

## Interface

- `CORE_LAT`, default 2: cycles from operand registers changing to `core_res` being valid; legal range 1..7.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0_valid`  in  1  requester 0 has an operation.
- `req0_ready`  out  1  block accepts requester 0's operation this cycle.
- `req0_a`  in  32  IEEE-754 single operand A.
- `req0_b`  in  32  IEEE-754 single operand B.
- `req0_sub`  in  1  1 = compute A−B, 0 = A+B.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_sub`: same as requester 0, for requester 1.
- `core_a`  out  32  registered operand A to adder core.
- `core_b`  out  32  registered operand B to adder core, sign already adjusted for subtract.
- `core_res`  in  32  adder core result.
- `rsp0_valid`  out  1  result for requester 0 available.
- `rsp0_data`  out  32  result for requester 0.
- `rsp0_ready`  in  1  requester 0 consumes result.
- `rsp1_valid`, `rsp1_data`, `rsp1_ready`: same as response channel 0, for requester 1.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation

- FSM states:
  - IDLE: waiting for a request.
  - WAIT: core latency countdown.
  - RESP: result held for the owning requester.
- Grant in IDLE (combinational from valids):
  - Only req0 valid → grant 0.
  - Only req1 valid → grant 1.
  - Both valid → grant = `prio` (1-bit pointer).
  - `reqN_ready` = (state==IDLE) && grant==N. Never both high. Both low outside IDLE.
- Accept (IDLE, valid && ready of granted N):
  - `core_a` ← `reqN_a`.
  - `core_b` ← {`reqN_b[31]` ^ `reqN_sub`, `reqN_b[30:0]`}.
  - `owner` ← N.
  - `prio` ← ~N.
  - `cnt` ← CORE_LAT−1.
  - Go to WAIT.
- WAIT:
  - If `cnt`≠0: decrement `cnt`.
  - If `cnt`==0: capture `core_res` into the result register, set `rsp<owner>_valid`, go to RESP.
- RESP:
  - `rsp<owner>_valid`=1 and `rsp<owner>_data`=result. Other channel's valid=0.
  - On `rsp<owner>_ready`=1: clear valid and go to IDLE.
  - The non-owner's `rspM_ready` is ignored.
- `core_a`/`core_b` hold their values from accept until the next accept; the core output is stable through the capture edge.
- `rspN_data` holds its last value when `rspN_valid`=0. Only the owner's data register updates on capture.
- Requester protocol: `reqN_valid` and operands stay stable until handshake. The block does not sample them outside the accept edge.
- No special-value handling in this block (NaN/Inf/zero pass through the core unchanged). Subtract is only a sign flip of B.

## Timing

- Reset (async, immediate):
  - state=IDLE, `prio`=0, `cnt`=0.
  - `core_a`=`core_b`=0.
  - `rsp0/1_valid`=0, `rsp0/1_data`=0.
  - `busy`=0; `req0/1_ready` follow the IDLE grant rule.
- Reset during WAIT or RESP discards the operation; no response is produced.
- Accept at edge k → result captured at edge k+CORE_LAT → `rspN_valid` high from cycle after edge k+CORE_LAT.
- `rspN_ready` high in the first valid cycle → IDLE after the next edge. Earliest next accept is edge k+CORE_LAT+2, giving peak throughput of 1 op per CORE_LAT+2 cycles.
- A response stalled by `rsp_ready`=0 blocks all new accepts. Both `req_ready` stay 0 until it is consumed.
- `busy` is high from the cycle after accept through the last RESP cycle.

## Test plan

- **Basic add:** CORE_LAT=2; req0 sends a=0x3F800000, b=0x40000000, sub=0, accepted at edge k. Required:
  - `core_b`=0x40000000.
  - `rsp0_valid` rises after edge k+2 with `rsp0_data`=0x40400000.
  - `rsp1_valid` stays 0.
- **Subtract:** req1 sends a=0x40400000, b=0x3F800000, sub=1. Required: `core_b`=0xBF800000 and `rsp1_data`=0x40000000.
- **Round-robin:** both requesters hold valid continuously from reset with rsp_ready=1. Required:
  - Grants alternate 0,1,0,1.
  - Accept edges are spaced exactly CORE_LAT+2 cycles.
  - Each response appears on the correct channel.
- **Backpressure:** `rsp0_ready`=0 for 5 cycles while req1 is valid. Required:
  - `rsp0_valid` and `rsp0_data` are held stable.
  - `req1_ready`=0 throughout.
  - req1 is accepted 2 edges after `rsp0_ready` rises.
- **Latency sweep:** CORE_LAT=1 and 7 against a behavioural adder model delayed CORE_LAT cycles. Required: the response cycle equals accept edge + CORE_LAT, and data matches the model for 200 random operand pairs.
- **Reset mid-operation:** assert `rst_n`=0 during WAIT. Required:
  - All outputs take their reset values asynchronously.
  - No response follows.
  - After release, req0 wins a simultaneous request because `prio`=0.

Source files
------------

// File: rtl/fpu_add_sched.sv
// fpu_add_sched
// Shares one single-precision adder core between two requesters. Operations
// are granted round-robin, driven to the core from registers, and the core
// result is captured after CORE_LAT cycles. It is then returned on the owning
// requester's response channel. Only one operation is in flight at a time.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req{0,1}_valid/_ready      request handshake
//   req{0,1}_a/_b/_sub         operands, sub=1 computes a-b
//   core_a/core_b              registered operands to the core (b sign-adjusted)
//   core_res                   core result, valid CORE_LAT cycles after operands
//   rsp{0,1}_valid/_data/_ready response handshake
//   busy                       high whenever the sequencer is not idle
//
// state  | meaning
// S_IDLE | waiting for a request; grant decided combinationally
// S_WAIT | core latency countdown
// S_RESP | result held for the owning requester
module fpu_add_sched #(
    parameter int CORE_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req0_sub,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic        req1_sub,
    output logic [31:0] core_a,
    output logic [31:0] core_b,
    input  logic [31:0] core_res,
    output logic        rsp0_valid,
    output logic [31:0] rsp0_data,
    input  logic        rsp0_ready,
    output logic        rsp1_valid,
    output logic [31:0] rsp1_data,
    input  logic        rsp1_ready,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [2:0] LAT_M1 = 3'(CORE_LAT - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_prio;
    logic        r_owner;
    logic [2:0]  r_cnt;
    logic [31:0] r_core_a;
    logic [31:0] r_core_b;
    logic        r_rsp0_valid;
    logic        r_rsp1_valid;
    logic [31:0] r_rsp0_data;
    logic [31:0] r_rsp1_data;

    logic        w_grant;
    logic        w_accept;
    logic        w_rsp_take;
    logic        w_cnt_zero;
    logic [31:0] w_sel_a;
    logic [31:0] w_sel_b;
    logic        w_sel_sub;

    // With no contention the lone requester wins; otherwise the pointer decides.
    always_comb begin
        w_grant = r_prio;
        if (req0_valid && !req1_valid) begin
            w_grant = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            w_grant = 1'b1;
        end
    end

    assign w_accept   = (r_state == S_IDLE) && (w_grant ? req1_valid : req0_valid);
    assign w_rsp_take = r_owner ? rsp1_ready : rsp0_ready;
    assign w_cnt_zero = (r_cnt == 3'd0);
    assign w_sel_a    = w_grant ? req1_a   : req0_a;
    assign w_sel_b    = w_grant ? req1_b   : req0_b;
    assign w_sel_sub  = w_grant ? req1_sub : req0_sub;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        case (r_state)
            S_IDLE: begin
                req0_ready = !w_grant;
                req1_ready = w_grant;
                if (w_accept) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (w_rsp_take) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio       <= 1'b0;
            r_owner      <= 1'b0;
            r_cnt        <= 3'd0;
            r_core_a     <= 32'd0;
            r_core_b     <= 32'd0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp0_data  <= 32'd0;
            r_rsp1_data  <= 32'd0;
        end else begin
            if (w_accept) begin
                r_core_a <= w_sel_a;
                // Subtract is folded into the operand as a sign flip of B.
                r_core_b <= {w_sel_b[31] ^ w_sel_sub, w_sel_b[30:0]};
                r_owner  <= w_grant;
                r_prio   <= ~w_grant;
                r_cnt    <= LAT_M1;
            end
            if (r_state == S_WAIT) begin
                if (!w_cnt_zero) begin
                    r_cnt <= r_cnt - 3'd1;
                end else if (r_owner) begin
                    r_rsp1_data  <= core_res;
                    r_rsp1_valid <= 1'b1;
                end else begin
                    r_rsp0_data  <= core_res;
                    r_rsp0_valid <= 1'b1;
                end
            end
            if ((r_state == S_RESP) && w_rsp_take) begin
                r_rsp0_valid <= 1'b0;
                r_rsp1_valid <= 1'b0;
            end
        end
    end

    assign core_a     = r_core_a;
    assign core_b     = r_core_b;
    assign rsp0_valid = r_rsp0_valid;
    assign rsp1_valid = r_rsp1_valid;
    assign rsp0_data  = r_rsp0_data;
    assign rsp1_data  = r_rsp1_data;
    assign busy       = (r_state != S_IDLE);

endmodule
